// File: rtl/hssl_reg_wr_arb.sv
// Register-write arbiter with lock ownership and idle-lock timeout.
// Define HSSL_ARB_RR_EN for round-robin selection (default: fixed priority).
`timescale 1ns/1ps
`ifndef REG_ADR_BITS
`define REG_ADR_BITS 8
`endif

module hssl_reg_wr_arb #(
  parameter int NUM_REQS = 3,
  parameter int LOCK_TMO = 16
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic [NUM_REQS-1:0]                    req_vld_in,
  input  logic [NUM_REQS-1:0]                    req_lock_in,
  input  logic [NUM_REQS-1:0][`REG_ADR_BITS-1:0] req_addr_in,
  input  logic [NUM_REQS-1:0][31:0]              req_data_in,
  output logic [NUM_REQS-1:0]                    req_rdy_out,
  input  logic                                   hold_in,
  output logic [`REG_ADR_BITS-1:0]               prx_addr_out,
  output logic [31:0]                            prx_wdata_out,
  output logic                                   prx_en_out,
  output logic                                   locked_out,
  output logic [15:0]                            tmo_cnt_out
);

  localparam int IW = $clog2(NUM_REQS);
  localparam int AW = `REG_ADR_BITS;
  localparam logic [7:0] TMO_M1 = 8'(LOCK_TMO - 1);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [7:0]      idle_q, idle_d;
  logic [15:0]     tmo_q, tmo_d;
  logic            en_q, en_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   acc_idx;
  logic            acc;

`ifdef HSSL_ARB_RR_EN
  localparam logic [IW:0] NR = (IW+1)'(NUM_REQS);

  logic [IW-1:0]           ptr_q, ptr_d;
  logic [2*NUM_REQS-1:0]   dbl;
  logic [NUM_REQS-1:0]     rot;
  logic [IW-1:0]           off;
  logic [IW:0]             sum;
  logic [IW:0]             nxt;

  // Rotate valids so the search starts at ptr_q, then map back.
  always_comb begin
    dbl = {req_vld_in, req_vld_in} >> ptr_q;
    rot = dbl[NUM_REQS-1:0];
    off = '0;
    for (int k = NUM_REQS-1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    sel_idx = (sum >= NR) ? IW'(sum - NR) : IW'(sum);
  end

  always_comb begin
    nxt = {1'b0, acc_idx} + 1'b1;
    ptr_d = ptr_q;
    if (acc) ptr_d = (nxt >= NR) ? '0 : IW'(nxt);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int k = NUM_REQS-1; k >= 0; k--) begin
      if (req_vld_in[k]) sel_idx = IW'(k);
    end
  end
`endif

  always_comb begin
    req_rdy_out = '0;
    acc_idx = (state_q == ST_LOCKED) ? owner_q : sel_idx;
    if (resetn && !hold_in) begin
      unique case (state_q)
        ST_ARB:    if (|req_vld_in) req_rdy_out = NUM_REQS'(1) << sel_idx;
        ST_LOCKED: if (req_vld_in[owner_q]) req_rdy_out = NUM_REQS'(1) << owner_q;
        default:   req_rdy_out = '0;
      endcase
    end
    acc = |req_rdy_out;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    idle_d  = idle_q;
    tmo_d   = tmo_q;
    en_d    = acc;
    addr_d  = acc ? req_addr_in[acc_idx] : addr_q;
    data_d  = acc ? req_data_in[acc_idx] : data_q;
    if (!hold_in) begin
      unique case (state_q)
        ST_ARB: begin
          if (acc && req_lock_in[acc_idx]) begin
            state_d = ST_LOCKED;
            owner_d = acc_idx;
            idle_d  = '0;
          end
        end
        ST_LOCKED: begin
          if (acc) begin
            idle_d = '0;
            if (!req_lock_in[acc_idx]) state_d = ST_ARB;
          end else if (idle_q == TMO_M1) begin
            state_d = ST_ARB;
            idle_d  = '0;
            if (tmo_q != 16'hffff) tmo_d = tmo_q + 16'd1;
          end else begin
            idle_d = idle_q + 8'd1;
          end
        end
        default: state_d = ST_ARB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_ARB;
      owner_q <= '0;
      idle_q  <= '0;
      tmo_q   <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      idle_q  <= idle_d;
      tmo_q   <= tmo_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign prx_en_out    = en_q;
  assign prx_addr_out  = addr_q;
  assign prx_wdata_out = data_q;
  assign locked_out    = (state_q == ST_LOCKED);
  assign tmo_cnt_out   = tmo_q;

endmodule

// File: doc/hssl_reg_wr_arb.md
HSSL_REG_WR_ARB -- requirements
Module: hssl_reg_wr_arb

Interface
REQ-001 SHALL have parameter NUM_REQS, default 3: number of register-write requesters (2..8).
REQ-002 SHALL have parameter LOCK_TMO, default 16: idle cycles before a held lock is revoked (1..255).
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_vld_in, input, NUM_REQS: per-requester write request valid.
REQ-006 SHALL have port req_lock_in, input, NUM_REQS: requester wants to keep the grant after this beat.
REQ-007 SHALL have port req_addr_in, input, [`REG_ADR_BITS-1:0] x NUM_REQS: register word address.
REQ-008 SHALL have port req_data_in, input, [31:0] x NUM_REQS: register write data.
REQ-009 SHALL have port req_rdy_out, output, NUM_REQS: beat accepted this cycle (one-hot or zero).
REQ-010 SHALL have port hold_in, input, 1: suspend all grants.
REQ-011 SHALL have ports prx_addr_out (`REG_ADR_BITS), prx_wdata_out (32), prx_en_out (1), outputs: register-bank packet write port.
REQ-012 SHALL have port locked_out, output, 1: arbiter in LOCKED state.
REQ-013 SHALL have port tmo_cnt_out, output, 16: count of lock timeouts, saturating.

Function
REQ-014 SHALL accept a beat from requester i when req_vld_in[i] && req_rdy_out[i]; req_rdy_out is combinational from valid, state, pointer and hold_in.
REQ-015 SHALL assert at most one req_rdy_out bit per cycle and none while hold_in=1.
REQ-016 SHALL register an accepted beat into prx_addr_out/prx_wdata_out with prx_en_out=1 on the next cycle (latency 1, throughput 1 beat/cycle).
REQ-017 SHALL drive prx_en_out=0 in any cycle following one with no accepted beat; prx_addr_out/prx_wdata_out hold their last value.
REQ-018 SHALL implement FSM states ARB and LOCKED.
REQ-019 In ARB, SHALL grant one valid requester per the selection rule (REQ-030/031); if the accepted beat has req_lock_in=1, SHALL move to LOCKED with owner = granted index.
REQ-020 In LOCKED, SHALL grant only the owner; other requesters see req_rdy_out=0.
REQ-021 In LOCKED, an accepted owner beat with req_lock_in=0 SHALL return the FSM to ARB next cycle.
REQ-022 In LOCKED, SHALL count consecutive cycles with owner valid=0 and hold_in=0; counter clears on any owner beat.
REQ-023 When that counter reaches LOCK_TMO, SHALL return to ARB next cycle and increment tmo_cnt_out (saturate at 16'hffff).
REQ-024 hold_in=1 SHALL freeze FSM state, owner and timeout counter.
REQ-025 SHALL drive locked_out=1 exactly while in LOCKED.
REQ-026 Owner valid with lock=1 on every beat SHALL keep LOCKED indefinitely (no starvation guard beyond timeout).

Reset
REQ-027 SHALL, on resetn=0, asynchronously force: FSM=ARB, owner=0, pointer=0, timeout counter=0, prx_en_out=0, prx_addr_out=0, prx_wdata_out=0, tmo_cnt_out=0, locked_out=0.
REQ-028 SHALL drive req_rdy_out=0 while resetn=0.
REQ-029 Reset mid-lock SHALL discard lock ownership; the in-flight registered beat SHALL NOT be issued.

Configuration
REQ-030 With HSSL_ARB_RR_EN defined, SHALL select in ARB round-robin: search starts at index (last granted + 1) mod NUM_REQS; pointer updates only on an accepted beat.
REQ-031 Without HSSL_ARB_RR_EN, SHALL select fixed priority, lowest index highest; no pointer register exists.

Verification
REQ-032 Req0 valid, addr=0x12, data=0xDEAD_BEEF, lock=0 -> req_rdy_out=3'b001 same cycle; next cycle prx_en_out=1, prx_addr_out=0x12, prx_wdata_out=0xDEAD_BEEF.
REQ-033 All three valid, lock=0, for 6 cycles -> RR_EN: grants 0,1,2,0,1,2; no RR_EN: grants 0 x6.
REQ-034 Req1 sends 3 beats lock=1,1,0 while req0/req2 valid -> grants 1,1,1, locked_out=1 for the 2 cycles between, then ARB grants req2 (RR_EN).
REQ-035 Req2 beat with lock=1 then drops valid, LOCK_TMO=16 -> locked_out falls after 16 idle cycles, tmo_cnt_out 0->1, req0 granted following cycle.
REQ-036 hold_in=1 for 5 cycles during LOCKED with owner idle -> no grants, prx_en_out=0, timeout count unchanged; resetn pulse mid-lock -> all outputs 0, FSM ARB.
